// File: rtl/tlb_probe_arbiter_pkg.sv
// Shared TLB types: the entry layout returned by the slow TLB and the probe FSM states.
package TLBTypes;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } TLBEntry;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } tlb_state_e;

endpackage

// File: rtl/tlb_rr_arbiter.sv
// Round-robin pick: the first requesting port found scanning upward from ptr, wrapping.
module tlb_rr_arbiter #(
  parameter int NUM_PORTS = 3
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic [NUM_PORTS-1:0]         grant
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      // ptr + i spans at most 2*NUM_PORTS-2, so one subtraction wraps it
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_PORTS)) sum = sum - (PTR_W+1)'(NUM_PORTS);
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlb_probe_arbiter.sv
// Arbitrates TLB probe requests from several ports onto one slow, group-serial TLB search
// engine, with a miss timeout and restart of the search whenever the TLB is written.
module tlb_probe_arbiter
  import TLBTypes::*;
#(
  parameter int NUM_PORTS      = 3,
  parameter int ENTRIES        = 64,
  parameter int GROUP_SIZE     = 4,
  parameter int TIMEOUT        = ENTRIES / GROUP_SIZE,
  parameter int PORT0_PRIORITY = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*VPN2_W-1:0]   req_vpn2,
  input  logic [NUM_PORTS*ASID_W-1:0]   req_asid,
  output logic [NUM_PORTS-1:0]          resp_ready,
  output logic [NUM_PORTS-1:0]          resp_miss,
  output logic [$clog2(ENTRIES)-1:0]    resp_index,
  output TLBEntry                       resp_entry,
  output logic [NUM_PORTS-1:0]          grant,
  output logic                          busy,
  input  logic                          w_valid,
  output logic                          s_valid,
  output logic [VPN2_W-1:0]             s_vpn2,
  output logic [ASID_W-1:0]             s_asid,
  input  logic                          s_ready,
  input  logic [$clog2(ENTRIES)-1:0]    s_index,
  input  TLBEntry                       s_resp
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  tlb_state_e           state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_PORTS-1:0] rr_grant;
  logic [NUM_PORTS-1:0] pick;
  logic [PTR_W-1:0]     pick_idx;
  logic                 owner_valid;
  logic [VPN2_W-1:0]    vpn_arr  [NUM_PORTS];
  logic [ASID_W-1:0]    asid_arr [NUM_PORTS];

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
    return (i == PTR_W'(NUM_PORTS - 1)) ? '0 : i + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_split
    assign vpn_arr[g]  = req_vpn2[g*VPN2_W +: VPN2_W];
    assign asid_arr[g] = req_asid[g*ASID_W +: ASID_W];
  end

  tlb_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (rr_grant)
  );

  // Software TLBP on port 0 overrides the rotation when enabled
  assign pick        = (PORT0_PRIORITY != 0 && req_valid[0]) ? NUM_PORTS'(1) : rr_grant;
  assign owner_valid = |(req_valid & grant);

  always_comb begin
    logic [NUM_PORTS-1:0] t;
    t        = pick;
    pick_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (t[0]) pick_idx = PTR_W'(i);
      t = t >> 1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_idx  <= '0;
      cnt        <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      s_valid    <= 1'b0;
      s_vpn2     <= '0;
      s_asid     <= '0;
      resp_ready <= '0;
      resp_miss  <= '0;
      resp_index <= '0;
      resp_entry <= '0;
    end else begin
      resp_ready <= '0;
      resp_miss  <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state     <= SEARCH;
            grant     <= pick;
            grant_idx <= pick_idx;
            cnt       <= '0;
            busy      <= 1'b1;
            s_valid   <= 1'b1;
            s_vpn2    <= vpn_arr[pick_idx];
            s_asid    <= asid_arr[pick_idx];
          end
        end
        SEARCH: begin
          if (!owner_valid) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            s_valid <= 1'b0;
            ptr     <= wrap_inc(grant_idx);
          end else if (w_valid) begin
            // A write may have changed the entry being looked for: search again from scratch
            cnt <= '0;
          end else if (s_ready) begin
            state      <= RESP;
            s_valid    <= 1'b0;
            resp_ready <= grant;
            resp_index <= s_index;
            resp_entry <= s_resp;
          end else begin
            cnt <= sat_inc(cnt);
            if (cnt == CNT_LAST) begin
              state     <= RESP;
              s_valid   <= 1'b0;
              resp_miss <= grant;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= wrap_inc(grant_idx);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_probe_arbiter.sv
// Bench for tlb_probe_arbiter: two instances (port-0 priority off / on) share all stimulus.
module tb_tlb_probe_arbiter;
  import TLBTypes::*;

  localparam int N  = 3;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req_valid;
  logic [N*19-1:0] req_vpn2;
  logic [N*8-1:0]  req_asid;
  logic          w_valid, s_ready;
  logic [5:0]    s_index;
  TLBEntry       s_resp;

  logic [N-1:0]  o_rr [2];
  logic [N-1:0]  o_rm [2];
  logic [5:0]    o_idx [2];
  TLBEntry       o_entry [2];
  logic [N-1:0]  o_grant [2];
  logic          o_busy [2];
  logic          o_sval [2];
  logic [18:0]   o_vpn [2];
  logic [7:0]    o_asid [2];

  logic [18:0]   tb_vpn [N];
  logic [7:0]    tb_asid [N];

  int  m_owner [2];
  bit  m_inresp [2];
  int  m_left [2];
  int  m_next [2];
  logic [N-1:0] m_rr [2];
  logic [N-1:0] m_rm [2];
  logic [5:0]   m_idx [2];
  TLBEntry      m_entry [2];
  logic [18:0]  m_vpn [2];
  logic [7:0]   m_asid [2];

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tlb_probe_arbiter #(
      .NUM_PORTS(N), .ENTRIES(64), .GROUP_SIZE(4), .TIMEOUT(TO), .PORT0_PRIORITY(g)
    ) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_vpn2(req_vpn2),
      .req_asid(req_asid), .resp_ready(o_rr[g]), .resp_miss(o_rm[g]),
      .resp_index(o_idx[g]), .resp_entry(o_entry[g]), .grant(o_grant[g]),
      .busy(o_busy[g]), .w_valid(w_valid), .s_valid(o_sval[g]), .s_vpn2(o_vpn[g]),
      .s_asid(o_asid[g]), .s_ready(s_ready), .s_index(s_index), .s_resp(s_resp)
    );
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return ((v >> i) & 3'b001) != 3'b000;
  endfunction

  // Port-0 priority applies to instance 1 only; otherwise scan upward from the rotation start
  function automatic int choose(input int d, input logic [N-1:0] req, input int start);
    if (d == 1 && bit_of(req, 0)) return 0;
    for (int k = 0; k < N; k++)
      if (bit_of(req, (start + k) % N)) return (start + k) % N;
    return -1;
  endfunction

  function automatic TLBEntry rand_entry();
    logic [95:0] v;
    v = {$urandom(), $urandom(), $urandom()};
    return v[77:0];
  endfunction

  task automatic drive_fields();
    req_vpn2 = {tb_vpn[2], tb_vpn[1], tb_vpn[0]};
    req_asid = {tb_asid[2], tb_asid[1], tb_asid[0]};
  endtask

  always @(posedge clock or posedge reset) begin : model
    int p;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_owner[d] = -1; m_inresp[d] = 0; m_left[d] = 0; m_next[d] = 0;
        m_rr[d] = '0; m_rm[d] = '0; m_idx[d] = '0; m_entry[d] = '0;
        m_vpn[d] = '0; m_asid[d] = '0;
      end else begin
        m_rr[d] = '0;
        m_rm[d] = '0;
        if (m_owner[d] < 0) begin
          p = choose(d, req_valid, m_next[d]);
          if (p >= 0) begin
            m_owner[d] = p;
            m_left[d]  = TO;
            m_vpn[d]   = 19'(req_vpn2 >> (p * 19));
            m_asid[d]  = 8'(req_asid >> (p * 8));
          end
        end else if (m_inresp[d]) begin
          m_inresp[d] = 0;
          m_next[d]   = (m_owner[d] + 1) % N;
          m_owner[d]  = -1;
        end else if (!bit_of(req_valid, m_owner[d])) begin
          m_next[d]  = (m_owner[d] + 1) % N;
          m_owner[d] = -1;
        end else if (w_valid) begin
          m_left[d] = TO;
        end else if (s_ready) begin
          m_inresp[d] = 1;
          m_rr[d]     = 3'b001 << m_owner[d];
          m_idx[d]    = s_index;
          m_entry[d]  = s_resp;
        end else begin
          m_left[d]--;
          if (m_left[d] == 0) begin
            m_inresp[d] = 1;
            m_rm[d]     = 3'b001 << m_owner[d];
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d grant", d), o_grant[d],
            (m_owner[d] < 0) ? 3'b000 : 3'b001 << m_owner[d]);
        chk($sformatf("d%0d busy", d), o_busy[d], m_owner[d] >= 0);
        chk($sformatf("d%0d s_valid", d), o_sval[d], m_owner[d] >= 0 && !m_inresp[d]);
        chk($sformatf("d%0d resp_ready", d), o_rr[d], m_rr[d]);
        chk($sformatf("d%0d resp_miss", d), o_rm[d], m_rm[d]);
        chk($sformatf("d%0d resp_index", d), o_idx[d], m_idx[d]);
        chk($sformatf("d%0d resp_entry", d), o_entry[d], m_entry[d]);
        chk($sformatf("d%0d s_vpn2", d), o_vpn[d], m_vpn[d]);
        chk($sformatf("d%0d s_asid", d), o_asid[d], m_asid[d]);
      end
    end
  end

  task automatic chk_zero(input string tag, input int d);
    chk($sformatf("%s d%0d grant", tag, d), o_grant[d], 0);
    chk($sformatf("%s d%0d busy", tag, d), o_busy[d], 0);
    chk($sformatf("%s d%0d s_valid", tag, d), o_sval[d], 0);
    chk($sformatf("%s d%0d resp_ready", tag, d), o_rr[d], 0);
    chk($sformatf("%s d%0d resp_miss", tag, d), o_rm[d], 0);
    chk($sformatf("%s d%0d resp_index", tag, d), o_idx[d], 0);
    chk($sformatf("%s d%0d resp_entry", tag, d), o_entry[d], 0);
  endtask

  initial begin
    TLBEntry hit_e;
    logic [N-1:0] nreq;
    req_valid = '0; w_valid = 1'b0; s_ready = 1'b0; s_index = '0; s_resp = '0;
    for (int p = 0; p < N; p++) begin
      tb_vpn[p]  = 19'($urandom());
      tb_asid[p] = 8'($urandom());
    end
    drive_fields();
    #1 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk_zero("reset", d);
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Round-robin between ports 1 and 2, then port 0 joins
    for (int c = 0; c <= 12; c++) begin
      @(negedge clock);
      if (c == 1) chk("rr c1 grant", o_grant[0], 3'b010);
      if (c == 4) chk("rr c4 grant", o_grant[0], 3'b100);
      if (c == 7) chk("rr c7 grant", o_grant[0], 3'b010);
      if (c == 10) begin
        chk("prio1 c10 grant", o_grant[1], 3'b001);
        chk("prio0 c10 grant", o_grant[0], 3'b100);
      end
      if (c == 0) begin req_valid = 3'b110; s_ready = 1'b1; end
      if (c == 8) req_valid = 3'b111;
      if (c == 10) begin req_valid = 3'b000; s_ready = 1'b0; end
    end

    // Hit on port 0 at search cycle 3
    hit_e = rand_entry();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clock);
      if (c == 1) chk("hit c1 s_vpn2", o_vpn[1], tb_vpn[0]);
      if (c == 3) begin
        chk("hit c3 s_valid", o_sval[1], 1);
        chk("hit c3 resp_ready", o_rr[1], 0);
      end
      if (c == 4) begin
        chk("hit c4 resp_ready", o_rr[1], 3'b001);
        chk("hit c4 resp_miss", o_rm[1], 0);
        chk("hit c4 resp_index", o_idx[1], 5);
        chk("hit c4 resp_entry", o_entry[1], hit_e);
      end
      if (c == 5) begin
        chk("hit c5 resp_ready", o_rr[1], 0);
        chk("hit c5 grant", o_grant[1], 0);
        chk("hit c5 resp_index held", o_idx[1], 5);
      end
      if (c == 0) req_valid = 3'b001;
      if (c == 3) begin s_ready = 1'b1; s_index = 6'd5; s_resp = hit_e; end
      if (c == 4) begin req_valid = '0; s_ready = 1'b0; s_index = 6'd33; s_resp = rand_entry(); end
    end

    // Plain miss on port 1
    for (int c = 0; c <= 19; c++) begin
      @(negedge clock);
      if (c == 16) begin
        chk("miss c16 s_valid", o_sval[1], 1);
        chk("miss c16 resp_miss", o_rm[1], 0);
      end
      if (c == 17) begin
        chk("miss c17 resp_miss", o_rm[1], 3'b010);
        chk("miss c17 resp_ready", o_rr[1], 0);
        chk("miss c17 s_valid", o_sval[1], 0);
      end
      if (c == 18) begin
        chk("miss c18 busy", o_busy[1], 0);
        chk("miss c18 resp_miss", o_rm[1], 0);
      end
      if (c == 0) req_valid = 3'b010;
      if (c == 17) req_valid = '0;
    end

    // Write at search cycle 5 restarts the timeout
    for (int c = 0; c <= 24; c++) begin
      @(negedge clock);
      if (c == 21) begin
        chk("wr c21 resp_miss", o_rm[1], 0);
        chk("wr c21 s_valid", o_sval[1], 1);
      end
      if (c == 22) chk("wr c22 resp_miss", o_rm[1], 3'b100);
      if (c == 23) chk("wr c23 busy", o_busy[1], 0);
      if (c == 0) req_valid = 3'b100;
      w_valid = (c == 5);
      if (c == 22) req_valid = '0;
    end

    // Cancel at cycle 4, then show the rotation moved past port 0
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      if (c == 4) chk("cancel c4 grant", o_grant[1], 3'b001);
      if (c == 5) begin
        chk("cancel c5 grant", o_grant[1], 0);
        chk("cancel c5 busy", o_busy[1], 0);
        chk("cancel c5 pulses", {o_rr[1], o_rm[1]}, 0);
      end
      if (c == 6) begin
        chk("cancel c6 prio0 grant", o_grant[0], 3'b100);
        chk("cancel c6 prio1 grant", o_grant[1], 3'b001);
      end
      if (c == 0) req_valid = 3'b001;
      if (c == 4) req_valid = '0;
      if (c == 5) req_valid = 3'b101;
      if (c == 6) req_valid = '0;
    end

    // Reset during SEARCH, then a normal request after release
    for (int c = 0; c <= 3; c++) begin
      @(negedge clock);
      if (c == 0) req_valid = 3'b010;
      if (c == 3) begin
        chk("rst c3 s_valid", o_sval[1], 1);
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk_zero("midreset", d);
      end
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c == 1) chk("post-rst c1 grant", o_grant[1], 3'b010);
      if (c == 3) begin
        chk("post-rst c3 resp_ready", o_rr[1], 3'b010);
        chk("post-rst c3 resp_index", o_idx[1], 9);
      end
      if (c == 4) chk("post-rst c4 grant", o_grant[1], 0);
      if (c == 2) begin s_ready = 1'b1; s_index = 6'd9; end
      if (c == 3) begin req_valid = '0; s_ready = 1'b0; end
    end

    // Random traffic: requests held and sometimes abandoned, sporadic hits, writes and resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      reset = 1'b0;
      nreq  = '0;
      for (int p = 0; p < N; p++) begin
        if (bit_of(req_valid, p)) begin
          if ($urandom_range(0, 39) != 0) nreq = nreq | (3'b001 << p);
        end else begin
          tb_vpn[p]  = 19'($urandom());
          tb_asid[p] = 8'($urandom());
          if ($urandom_range(0, 3) == 0) nreq = nreq | (3'b001 << p);
        end
      end
      req_valid = nreq;
      drive_fields();
      s_ready = ($urandom_range(0, 7) == 0);
      w_valid = ($urandom_range(0, 15) == 0);
      s_index = 6'($urandom());
      s_resp  = rand_entry();
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
      end
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
